// File: rtl/mreg_sequencer.sv
// mreg_sequencer
// Turns single-cycle commands (LOAD, SHL, SHR, ROTL) into the control stream
// of the downstream 4-bit multifunction register. The control stream is made
// of s (mode), d (parallel data) and shift_in (serial bit). Shift commands run
// a programmable number of steps. Consecutive steps are TICK_DIV cycles apart.
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous, active-high
//   start     command request, only looked at while idle
//   op        00 LOAD, 01 SHL, 10 SHR, 11 ROTL
//   data_in   LOAD value
//   count     shift steps 0..7 (ignored for LOAD)
//   fill      serial bit for SHL/SHR
//   q_fb      register output, used as the ROTL feedback bit
//   s         register mode: 00 hold, 01 load, 10 shift left, 11 shift right
//   d         register parallel data (last captured data_in)
//   shift_in  register serial input
//   busy      command in progress
//   done      one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start, s=00
// LOAD  | s=01 for one cycle
// STEP  | one shift step, remaining decrements
// GAP   | hold between steps, gap counter runs down
// DONE  | done pulse, still busy

module mreg_sequencer #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [3:0] data_in,
  input  logic [2:0] count,
  input  logic       fill,
  input  logic [3:0] q_fb,
  output logic [1:0] s,
  output logic [3:0] d,
  output logic       shift_in,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROTL = 2'b11;

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_SHL  = 2'b10;
  localparam logic [1:0] S_SHR  = 2'b11;

  localparam logic [7:0] GAP_INIT = 8'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP,
    GAP,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [3:0] data_q, data_d;
  logic       fill_q, fill_d;
  logic [2:0] remaining_q, remaining_d;
  logic [7:0] gap_q, gap_d;
  logic [1:0] s_q, s_d;
  logic       shift_fill_q, shift_fill_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Only the MSB of the register is fed back; the rest is intentionally unused.
  logic unused_q_fb;
  assign unused_q_fb = &{1'b0, q_fb[2:0]};

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    fill_d      = fill_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          data_d = data_in;
          fill_d = fill;
          if (op == OP_LOAD) begin
            remaining_d = 3'd0;
            state_d     = LOAD;
          end else if (count == 3'd0) begin
            remaining_d = 3'd0;
            state_d     = DONE;
          end else begin
            remaining_d = count;
            state_d     = STEP;
          end
        end
      end
      LOAD: state_d = DONE;
      STEP: begin
        // remaining is at least 1 here; the <= guard keeps it from wrapping.
        if (remaining_q <= 3'd1) begin
          remaining_d = 3'd0;
          state_d     = DONE;
        end else begin
          remaining_d = remaining_q - 3'd1;
          if (TICK_DIV == 1) begin
            state_d = STEP;
          end else begin
            gap_d   = GAP_INIT;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q <= 8'd1) begin
          gap_d   = 8'd0;
          state_d = STEP;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered and line up
  // with the state they belong to.
  always_comb begin
    s_d          = S_HOLD;
    shift_fill_d = 1'b0;
    case (state_d)
      LOAD: s_d = S_LOAD;
      STEP: begin
        s_d          = (op_d == OP_SHR) ? S_SHR : S_SHL;
        shift_fill_d = (op_d != OP_ROTL) & fill_d;
      end
      default: s_d = S_HOLD;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= 2'b00;
      data_q       <= 4'd0;
      fill_q       <= 1'b0;
      remaining_q  <= 3'd0;
      gap_q        <= 8'd0;
      s_q          <= S_HOLD;
      shift_fill_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      data_q       <= data_d;
      fill_q       <= fill_d;
      remaining_q  <= remaining_d;
      gap_q        <= gap_d;
      s_q          <= s_d;
      shift_fill_q <= shift_fill_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // ROTL must see the register's current MSB, so that path bypasses the flop.
  assign shift_in = (state_q == STEP && op_q == OP_ROTL) ? q_fb[3] : shift_fill_q;
  assign s        = s_q;
  assign d        = data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mreg_sequencer.sv
// Bench for mreg_sequencer. Two instances run the same stimulus in parallel.
// One uses TICK_DIV=4 and the other TICK_DIV=1. Each drives its own model of
// the downstream 4-bit register, whose output feeds back as q_fb.

module tb_mreg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, fill;
  logic [1:0] op;
  logic [3:0] data_in;
  logic [2:0] count;

  logic [3:0] q4 = 4'd0, q1 = 4'd0;
  logic [1:0] s4, s1;
  logic [3:0] d4, d1;
  logic       si4, si1, busy4, busy1, done4, done1;

  mreg_sequencer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in),
    .count(count), .fill(fill), .q_fb(q4), .s(s4), .d(d4), .shift_in(si4),
    .busy(busy4), .done(done4)
  );

  mreg_sequencer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in),
    .count(count), .fill(fill), .q_fb(q1), .s(s1), .d(d1), .shift_in(si1),
    .busy(busy1), .done(done1)
  );

  // Downstream register models
  always @(posedge clk) begin
    case (s4)
      2'b01:   q4 <= d4;
      2'b10:   q4 <= {q4[2:0], si4};
      2'b11:   q4 <= {si4, q4[3:1]};
      default: q4 <= q4;
    endcase
    case (s1)
      2'b01:   q1 <= d1;
      2'b10:   q1 <= {q1[2:0], si1};
      2'b11:   q1 <= {si1, q1[3:1]};
      default: q1 <= q1;
    endcase
  end

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    int         cnt;
    logic       fill;
    int         done_t4;  // expected done cycle, TICK_DIV=4
    int         done_t1;  // expected done cycle, TICK_DIV=1
    logic [3:0] q_exp;    // expected register contents afterwards
    int         poke;     // cycle with an extra start pulse (0 = none)
  } vec_t;

  vec_t vecs[12];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_s(input logic [1:0] o, input int n,
                                       input int c, input int t);
    if (o == 2'b00) return (c == 1) ? 2'b01 : 2'b00;
    if (c >= 1 && ((c - 1) % t) == 0 && ((c - 1) / t) < n)
      return (o == 2'b10) ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  task automatic check_cyc(input string tag, input int idx, input int c,
                           input int t, input int dn, input vec_t v,
                           input logic [1:0] s_a, input logic [3:0] d_a,
                           input logic si_a, input logic b_a, input logic dn_a);
    logic [1:0] se;
    string      p;
    se = exp_s(v.op, v.cnt, c, t);
    p  = $sformatf("v%0d %s c%0d", idx, tag, c);
    chk({p, " s"}, int'(s_a), int'(se));
    chk({p, " d"}, int'(d_a), int'(v.data));
    chk({p, " busy"}, int'(b_a), (c <= dn) ? 1 : 0);
    chk({p, " done"}, int'(dn_a), (c == dn) ? 1 : 0);
    if (!(v.op == 2'b11 && se != 2'b00))
      chk({p, " shift_in"}, int'(si_a), (se != 2'b00 && v.op != 2'b00) ? int'(v.fill) : 0);
  endtask

  // Called #1 after a rising edge with both instances idle.
  task automatic run_vec(input vec_t v, input int idx);
    int maxw;
    maxw    = ((v.done_t4 > v.done_t1) ? v.done_t4 : v.done_t1) + 1;
    op      = v.op;
    data_in = v.data;
    count   = 3'(v.cnt);
    fill    = v.fill;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    op      = ~v.op;
    data_in = ~v.data;
    count   = ~count;
    fill    = ~v.fill;
    for (int c = 1; c <= maxw; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      start = (c == v.poke);
      if (c == v.poke) begin
        op      = 2'b00;
        data_in = 4'b1111;
      end
      check_cyc("T4", idx, c, 4, v.done_t4, v, s4, d4, si4, busy4, done4);
      check_cyc("T1", idx, c, 1, v.done_t1, v, s1, d1, si1, busy1, done1);
    end
    start = 1'b0;
    chk($sformatf("v%0d T4 q", idx), int'(q4), int'(v.q_exp));
    chk($sformatf("v%0d T1 q", idx), int'(q1), int'(v.q_exp));
  endtask

  initial begin
    //           op     data     cnt fill d4 d1 q_exp  poke
    vecs[0]  = '{2'b00, 4'b1011, 0, 1'b0, 2, 2, 4'b1011, 0};
    vecs[1]  = '{2'b00, 4'b0001, 0, 1'b0, 2, 2, 4'b0001, 0};
    vecs[2]  = '{2'b01, 4'b0110, 3, 1'b1, 10, 4, 4'b1111, 0};
    vecs[3]  = '{2'b00, 4'b1001, 0, 1'b0, 2, 2, 4'b1001, 0};
    vecs[4]  = '{2'b11, 4'b0000, 2, 1'b0, 6, 3, 4'b0110, 0};
    vecs[5]  = '{2'b10, 4'b0101, 0, 1'b1, 1, 1, 4'b0110, 0};
    vecs[6]  = '{2'b00, 4'b1000, 0, 1'b0, 2, 2, 4'b1000, 0};
    vecs[7]  = '{2'b10, 4'b0011, 2, 1'b0, 6, 3, 4'b0010, 2};
    vecs[8]  = '{2'b01, 4'b1100, 7, 1'b1, 26, 8, 4'b1111, 0};
    vecs[9]  = '{2'b00, 4'b0110, 0, 1'b0, 2, 2, 4'b0110, 0};
    vecs[10] = '{2'b11, 4'b1010, 3, 1'b1, 10, 4, 4'b0011, 0};
    vecs[11] = '{2'b10, 4'b0000, 1, 1'b1, 2, 2, 4'b1001, 0};

    reset = 1'b1; start = 1'b0; op = 2'b00; data_in = 4'd0; count = 3'd0; fill = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst T4 s", int'(s4), 0);
    chk("rst T4 d", int'(d4), 0);
    chk("rst T4 si", int'(si4), 0);
    chk("rst T4 busy", int'(busy4), 0);
    chk("rst T4 done", int'(done4), 0);
    chk("rst T1 s", int'(s1), 0);
    chk("rst T1 busy", int'(busy1), 0);
    chk("rst T1 done", int'(done1), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle T4 busy", int'(busy4), 0);
    chk("idle T1 s", int'(s1), 0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset in cycle 6 of a long SHL aborts it with no done pulse.
    op = 2'b01; count = 3'd7; fill = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort T4 s", int'(s4), 0);
    chk("abort T4 busy", int'(busy4), 0);
    chk("abort T4 done", int'(done4), 0);
    chk("abort T1 s", int'(s1), 0);
    chk("abort T1 busy", int'(busy1), 0);
    chk("abort T1 done", int'(done1), 0);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post-abort c%0d T4 done", c), int'(done4), 0);
      chk($sformatf("post-abort c%0d T1 done", c), int'(done1), 0);
      chk($sformatf("post-abort c%0d T4 busy", c), int'(busy4), 0);
    end
    run_vec('{2'b00, 4'b0101, 0, 1'b0, 2, 2, 4'b0101, 0}, 12);

    // start held high: LOAD, done, one idle cycle, next LOAD, ...
    op = 2'b00; data_in = 4'b1010; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (c == 9) start = 1'b0;
      chk($sformatf("b2b c%0d T4 s", c), int'(s4), (c % 3 == 1) ? 1 : 0);
      chk($sformatf("b2b c%0d T4 busy", c), int'(busy4), (c % 3 != 0) ? 1 : 0);
      chk($sformatf("b2b c%0d T4 done", c), int'(done4), (c % 3 == 2) ? 1 : 0);
      chk($sformatf("b2b c%0d T1 s", c), int'(s1), (c % 3 == 1) ? 1 : 0);
      chk($sformatf("b2b c%0d T1 done", c), int'(done1), (c % 3 == 2) ? 1 : 0);
    end
    chk("b2b T4 q", int'(q4), 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mreg_sequencer.md
# mreg_sequencer

Command sequencer directly upstream of the 4-bit multifunction register. It turns single-cycle commands into the register's control stream: `s`, `d` and `shift_in`. Supported commands are load, shift-left, shift-right and rotate-left, with a programmable number of steps and a programmable step spacing. A start/busy/done handshake lets the top-level FSM or button debouncer issue one command at a time.

## Interface
- `TICK_DIV`, default 4: clock cycles between successive shift steps. Legal range 1..255; 1 means back-to-back steps.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  command request; sampled only when `busy`=0.
- `op`  in  2  command: 00 LOAD, 01 SHL (fill), 10 SHR (fill), 11 ROTL.
- `data_in`  in  4  load value for LOAD.
- `count`  in  3  number of shift steps, 0..7; ignored for LOAD.
- `fill`  in  1  serial bit inserted by SHL/SHR.
- `q_fb`  in  4  register output `q`, fed back for ROTL.
- `s`  out  2  register mode: 00 hold, 01 load `d`, 10 shift left (`shift_in` enters bit 0), 11 shift right (`shift_in` enters bit 3).
- `d`  out  4  register parallel data.
- `shift_in`  out  1  register serial input.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, STEP, GAP, DONE.
- **IDLE**
  - `s`=00, `busy`=0.
  - On `start`=1, capture `op`, `data_in`, `count` and `fill` into internal registers.
  - LOAD goes to LOAD.
  - Shift ops with `count`=0 go to DONE.
  - Otherwise go to STEP with `remaining`=`count`.
- **LOAD**: `s`=01 and `d`=captured data for exactly one cycle, then DONE.
- **STEP**
  - `s`=10 (SHL, ROTL) or 11 (SHR) for exactly one cycle.
  - `shift_in` is the captured `fill` for SHL/SHR, or `q_fb[3]` combinationally for ROTL.
  - `remaining` decrements.
  - If `remaining` becomes 0, go to DONE.
  - Else go to GAP, or straight back to STEP when `TICK_DIV`=1.
- **GAP**: `s`=00 for `TICK_DIV`-1 cycles (down-counter), then STEP.
- **DONE**: `done`=1, `busy`=1, `s`=00 for one cycle, then IDLE.
- Default outputs outside the states above:
  - `s`=00.
  - `shift_in`=0 except in STEP.
  - `d` holds the last captured `data_in` (0 after reset).
- `start` while `busy`=1 is ignored and not queued. Input changes after capture have no effect. `q_fb` is read only in ROTL STEP cycles.
- Width rules:
  - `remaining` is 3 bits and never underflows; DONE is entered when it reaches 0.
  - The gap counter is 8 bits.
- Reset:
  - Reset values: state IDLE, `s`=00, `d`=0000, `shift_in`=0, `busy`=0, `done`=0, all counters 0.
  - Reset mid-command aborts it immediately with no `done` pulse.
  - Reset has priority over `start` in the same cycle.

## Timing
- Let E0 be the edge that samples `start`; "cycle n" is the n-th cycle after E0.
- LOAD:
  - `s`=01 in cycle 1, so the register updates at the end of cycle 1.
  - `done` in cycle 2.
  - `busy` is high in cycles 1–2.
- Shift with `count`=N>0:
  - Step k (k=0..N-1) is in cycle 1+k·`TICK_DIV`.
  - `done` is in cycle 2+(N-1)·`TICK_DIV`.
  - `busy` is high from cycle 1 through the `done` cycle.
- Shift with `count`=0: `done` in cycle 1 and no step.
- A new `start` is accepted no earlier than the cycle after `done`, so back-to-back commands are separated by one idle cycle.
- All outputs are registered except `shift_in` during ROTL, which is combinational from `q_fb`.

## Test plan
- Reset then LOAD: `reset` 2 cycles, then `start`, `op`=00, `data_in`=1011.
  - Required: `s`=01/`d`=1011 in cycle 1 only, `done` in cycle 2.
  - Register model reads 1011.
- SHL: from q=0001, `op`=01, `count`=3, `fill`=1, `TICK_DIV`=4.
  - Required: steps in cycles 1, 5, 9, `done` in cycle 10.
  - q sequence 0011, 0111, 1111.
- ROTL: from q=1001, `op`=11, `count`=2, `TICK_DIV`=1.
  - Required: steps in cycles 1–2, q goes 0011 then 0110, `done` in cycle 3.
- Zero count, and SHR with a blocked start:
  - SHR `count`=0: `done` in cycle 1, `s` stays 00.
  - SHR `count`=2 from 1000, `fill`=0: q goes 0100, 0010.
  - A `start` pulse in cycle 2 of the SHR is ignored.
- Reset mid-command: SHL `count`=7, assert `reset` in cycle 6.
  - Required: next cycle `s`=00, `busy`=0, no `done`.
  - The following `start` runs normally.
- Back-to-back commands: `start` held high continuously.
  - Required: each command begins the cycle after the previous `done`, with exactly one idle cycle between them.
